// File: rtl/regex_cpu_pipelined_core.sv
// Pipelined regex thread engine: FETCH -> WAIT_DATA -> EXECUTE -> output buffer.
// Define REGEX_CPU_OUTPUT_FIFO_EN for a 2**FIFO_WIDTH_POWER_OF_2 deep output FIFO; otherwise a single output register.
module regex_cpu_pipelined_core #(
    parameter int PC_WIDTH              = 9,
    parameter int CHARACTER_WIDTH       = 8,
    parameter int MEMORY_WIDTH          = 20,
    parameter int MEMORY_ADDR_WIDTH     = 11,
    parameter int FIFO_WIDTH_POWER_OF_2 = 2,
    parameter int CC_ID_BITS            = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0] current_characters,
    input  logic [(2**CC_ID_BITS)-1:0]                end_of_string,
    input  logic                                      input_pc_valid,
    output logic                                      input_pc_ready,
    input  logic [PC_WIDTH-1:0]                       input_pc,
    input  logic [CC_ID_BITS-1:0]                     input_cc_id,
    output logic                                      memory_valid,
    input  logic                                      memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]              memory_addr,
    input  logic [MEMORY_WIDTH-1:0]                   memory_data,
    output logic                                      output_pc_valid,
    input  logic                                      output_pc_ready,
    output logic [PC_WIDTH-1:0]                       output_pc,
    output logic [CC_ID_BITS-1:0]                     output_cc_id,
    output logic                                      accepts,
    output logic [(2**CC_ID_BITS)-1:0]                elaborating_chars,
    output logic                                      running
);
    localparam int NCC = 2 ** CC_ID_BITS;
    localparam int KEEP = (PC_WIDTH > CHARACTER_WIDTH) ? PC_WIDTH : CHARACTER_WIDTH;
    localparam int EW = PC_WIDTH + CC_ID_BITS;
`ifdef REGEX_CPU_OUTPUT_FIFO_EN
    localparam int unsigned DEPTH = 2 ** FIFO_WIDTH_POWER_OF_2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 2 ** PTR_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_ACCEPT         = 3'd0,
        OP_SPLIT          = 3'd1,
        OP_MATCH          = 3'd2,
        OP_JMP            = 3'd3,
        OP_END            = 3'd4,
        OP_MATCH_ANY      = 3'd5,
        OP_ACCEPT_PARTIAL = 3'd6,
        OP_NOT_MATCH      = 3'd7
    } op_e;

    logic                  f_valid_q, f_valid_d;
    logic [PC_WIDTH-1:0]   f_pc_q, f_pc_d;
    logic [CC_ID_BITS-1:0] f_cc_q, f_cc_d;
    logic                  w_valid_q, w_valid_d;
    logic [PC_WIDTH-1:0]   w_pc_q, w_pc_d;
    logic [CC_ID_BITS-1:0] w_cc_q, w_cc_d;
    logic                  e_valid_q, e_valid_d;
    logic [PC_WIDTH-1:0]   e_pc_q, e_pc_d;
    logic [CC_ID_BITS-1:0] e_cc_q, e_cc_d;
    op_e                   e_op_q, e_op_d;
    logic [KEEP-1:0]       e_data_q, e_data_d;
`ifndef REGEX_CPU_OUTPUT_FIFO_EN
    typedef enum logic {SPLIT_FIRST, SPLIT_SECOND} split_e;
    split_e                e_half_q, e_half_d;
`endif
    logic [EW-1:0]         fifo_q [SLOTS];
    logic [EW-1:0]         fifo_d [SLOTS];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  accepts_q, accepts_d;

    logic                  e_done, emit_acc, pop;
    logic [PC_WIDTH-1:0]   emit_a, emit_b, pc_inc, push0, push1;
    logic [CHARACTER_WIDTH-1:0] ch;
    logic                  eos;
    int unsigned           emit_n, push_n, free_n;
    logic                  unused_data;

    assign unused_data = ^memory_data[MEMORY_WIDTH-4:KEEP];

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        f_valid_d = f_valid_q;
        f_pc_d    = f_pc_q;
        f_cc_d    = f_cc_q;
        w_valid_d = 1'b0;
        w_pc_d    = w_pc_q;
        w_cc_d    = w_cc_q;
        e_valid_d = e_valid_q;
        e_pc_d    = e_pc_q;
        e_cc_d    = e_cc_q;
        e_op_d    = e_op_q;
        e_data_d  = e_data_q;
`ifndef REGEX_CPU_OUTPUT_FIFO_EN
        e_half_d  = e_half_q;
`endif
        fifo_d    = fifo_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        emit_n    = 0;
        emit_acc  = 1'b0;
        push_n    = 0;
        e_done    = 1'b0;
        pc_inc    = e_pc_q + PC_WIDTH'(1);
        emit_a    = pc_inc;
        emit_b    = e_data_q[PC_WIDTH-1:0];
        push0     = emit_a;
        push1     = emit_b;
        ch        = current_characters[32'(e_cc_q) * CHARACTER_WIDTH +: CHARACTER_WIDTH];
        eos       = end_of_string[e_cc_q];

        pop    = (count_q != '0) && output_pc_ready;
        free_n = DEPTH - 32'(count_q) + (pop ? 1 : 0);

        unique case (e_op_q)
            OP_ACCEPT:         emit_acc = eos;
            OP_SPLIT:          emit_n = 2;
            OP_MATCH:          emit_n = (ch == e_data_q[CHARACTER_WIDTH-1:0]) ? 1 : 0;
            OP_JMP: begin
                emit_n = 1;
                emit_a = e_data_q[PC_WIDTH-1:0];
            end
            OP_END:            emit_n = 0;
            OP_MATCH_ANY:      emit_n = eos ? 0 : 1;
            OP_ACCEPT_PARTIAL: emit_acc = 1'b1;
            OP_NOT_MATCH:      emit_n = (ch != e_data_q[CHARACTER_WIDTH-1:0]) ? 1 : 0;
            default:           emit_n = 0;
        endcase

        if (e_valid_q) begin
`ifdef REGEX_CPU_OUTPUT_FIFO_EN
            e_done = (emit_n <= free_n);
            push_n = e_done ? emit_n : 0;
            push0  = emit_a;
`else
            // SPLIT holds EXECUTE for a second cycle to emit its jump target
            if (emit_n == 2) begin
                if (free_n >= 1) begin
                    push_n = 1;
                    if (e_half_q == SPLIT_FIRST) begin
                        push0    = emit_a;
                        e_half_d = SPLIT_SECOND;
                    end else begin
                        push0    = emit_b;
                        e_half_d = SPLIT_FIRST;
                        e_done   = 1'b1;
                    end
                end
            end else begin
                e_done = (emit_n <= free_n);
                push_n = e_done ? emit_n : 0;
                push0  = emit_a;
            end
`endif
        end

        if (push_n >= 1) begin
            fifo_d[wr_ptr_q] = {push0, e_cc_q};
            wr_ptr_d = nxt(wr_ptr_q);
        end
        if (push_n == 2) begin
            fifo_d[nxt(wr_ptr_q)] = {push1, e_cc_q};
            wr_ptr_d = nxt(nxt(wr_ptr_q));
        end
        if (pop) rd_ptr_d = nxt(rd_ptr_q);
        count_d   = CNT_W'(32'(count_q) + push_n - (pop ? 1 : 0));
        accepts_d = e_valid_q && e_done && emit_acc;

        // a fetch is only issued when EXECUTE is guaranteed free to take the returning word
        input_pc_ready = !f_valid_q;
        memory_valid   = f_valid_q && !w_valid_q && (!e_valid_q || e_done);
        memory_addr    = MEMORY_ADDR_WIDTH'(f_pc_q);

        if (memory_valid && memory_ready) begin
            f_valid_d = 1'b0;
            w_valid_d = 1'b1;
            w_pc_d    = f_pc_q;
            w_cc_d    = f_cc_q;
        end
        if (input_pc_valid && input_pc_ready) begin
            f_valid_d = 1'b1;
            f_pc_d    = input_pc;
            f_cc_d    = input_cc_id;
        end
        if (e_valid_q && e_done) e_valid_d = 1'b0;
        if (w_valid_q) begin
            e_valid_d = 1'b1;
            e_pc_d    = w_pc_q;
            e_cc_d    = w_cc_q;
            e_op_d    = op_e'(memory_data[MEMORY_WIDTH-1 -: 3]);
            e_data_d  = memory_data[KEEP-1:0];
        end
    end

    always_comb begin
        elaborating_chars = '0;
        if (f_valid_q) elaborating_chars[f_cc_q] = 1'b1;
        if (w_valid_q) elaborating_chars[w_cc_q] = 1'b1;
        if (e_valid_q) elaborating_chars[e_cc_q] = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((i + DEPTH - 32'(rd_ptr_q)) % DEPTH) < 32'(count_q))
                elaborating_chars[fifo_q[PTR_W'(i)][CC_ID_BITS-1:0]] = 1'b1;
        end
    end

    assign output_pc_valid = (count_q != '0);
    assign output_pc       = fifo_q[rd_ptr_q][EW-1:CC_ID_BITS];
    assign output_cc_id    = fifo_q[rd_ptr_q][CC_ID_BITS-1:0];
    assign accepts         = accepts_q;
    assign running         = f_valid_q || w_valid_q || e_valid_q || (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid_q <= 1'b0;
            f_pc_q    <= '0;
            f_cc_q    <= '0;
            w_valid_q <= 1'b0;
            w_pc_q    <= '0;
            w_cc_q    <= '0;
            e_valid_q <= 1'b0;
            e_pc_q    <= '0;
            e_cc_q    <= '0;
            e_op_q    <= OP_ACCEPT;
            e_data_q  <= '0;
`ifndef REGEX_CPU_OUTPUT_FIFO_EN
            e_half_q  <= SPLIT_FIRST;
`endif
            fifo_q    <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            accepts_q <= 1'b0;
        end else begin
            f_valid_q <= f_valid_d;
            f_pc_q    <= f_pc_d;
            f_cc_q    <= f_cc_d;
            w_valid_q <= w_valid_d;
            w_pc_q    <= w_pc_d;
            w_cc_q    <= w_cc_d;
            e_valid_q <= e_valid_d;
            e_pc_q    <= e_pc_d;
            e_cc_q    <= e_cc_d;
            e_op_q    <= e_op_d;
            e_data_q  <= e_data_d;
`ifndef REGEX_CPU_OUTPUT_FIFO_EN
            e_half_q  <= e_half_d;
`endif
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            accepts_q <= accepts_d;
        end
    end
endmodule

// File: tb/tb_regex_cpu_pipelined_core.sv
// Scoreboard bench for regex_cpu_pipelined_core: expected successor threads and accept counts
// come from an opcode-level reference model; a negedge monitor checks every output handshake.
module tb_regex_cpu_pipelined_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] current_characters;
    logic [3:0]  end_of_string = '0;
    logic        input_pc_valid = 1'b0;
    logic        input_pc_ready;
    logic [8:0]  input_pc = '0;
    logic [1:0]  input_cc_id = '0;
    logic        memory_valid;
    logic        memory_ready = 1'b0;
    logic [10:0] memory_addr;
    logic [19:0] memory_data = '0;
    logic        output_pc_valid;
    logic        output_pc_ready = 1'b0;
    logic [8:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        accepts;
    logic [3:0]  elaborating_chars;
    logic        running;

    regex_cpu_pipelined_core #(
        .PC_WIDTH(9), .CHARACTER_WIDTH(8), .MEMORY_WIDTH(20),
        .MEMORY_ADDR_WIDTH(11), .FIFO_WIDTH_POWER_OF_2(2), .CC_ID_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .current_characters(current_characters),
        .end_of_string(end_of_string), .input_pc_valid(input_pc_valid),
        .input_pc_ready(input_pc_ready), .input_pc(input_pc), .input_cc_id(input_cc_id),
        .memory_valid(memory_valid), .memory_ready(memory_ready), .memory_addr(memory_addr),
        .memory_data(memory_data), .output_pc_valid(output_pc_valid),
        .output_pc_ready(output_pc_ready), .output_pc(output_pc), .output_cc_id(output_cc_id),
        .accepts(accepts), .elaborating_chars(elaborating_chars), .running(running)
    );

    always #5 clk = ~clk;

    logic [19:0] prog [512];
    logic [7:0]  chars [4];
    assign current_characters = {chars[3], chars[2], chars[1], chars[0]};

    int          vectors = 0;
    int          miscompares = 0;
    logic [10:0] exp_q [$];
    int          exp_acc = 0;
    int          acc_seen = 0;
    int          hold_low = 0;
    logic        mem_hs = 1'b0;
    logic [10:0] mem_addr_l = '0;
    logic        prev_stall = 1'b0;
    logic [10:0] prev_out = '0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: effect of one thread, from the opcode table.
    task automatic model(input int pc, input int cc);
        logic [19:0] w;
        logic [2:0]  op;
        logic [7:0]  c;
        logic [8:0]  nx, tg;
        w  = prog[pc];
        op = w[19:17];
        c  = w[7:0];
        tg = w[8:0];
        nx = 9'((pc + 1) % 512);
        case (op)
            3'd0: if (end_of_string[cc]) exp_acc++;
            3'd1: begin exp_q.push_back({nx, 2'(cc)}); exp_q.push_back({tg, 2'(cc)}); end
            3'd2: if (chars[cc] == c) exp_q.push_back({nx, 2'(cc)});
            3'd3: exp_q.push_back({tg, 2'(cc)});
            3'd4: ;
            3'd5: if (!end_of_string[cc]) exp_q.push_back({nx, 2'(cc)});
            3'd6: exp_acc++;
            3'd7: if (chars[cc] != c) exp_q.push_back({nx, 2'(cc)});
            default: ;
        endcase
    endtask

    // Memory and output-ready environment
    always @(negedge clk) begin
        mem_hs     = memory_valid && memory_ready && !rst;
        mem_addr_l = memory_addr;
    end
    always @(posedge clk) begin
        #1;
        if (mem_hs) memory_data = prog[mem_addr_l[8:0]];
        else        memory_data = 20'($urandom);
        memory_ready = ($urandom_range(0, 3) != 0);
        if (hold_low > 0) begin
            output_pc_ready = 1'b0;
            hold_low--;
        end else begin
            output_pc_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (accepts) acc_seen++;
            if (prev_stall)
                check(output_pc_valid && ({output_pc, output_cc_id} == prev_out), "out_hold",
                      {output_pc_valid, output_pc, output_cc_id}, {1'b1, prev_out});
            prev_stall = output_pc_valid && !output_pc_ready;
            prev_out   = {output_pc, output_cc_id};
            if (output_pc_valid && output_pc_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_out", {output_pc, output_cc_id}, 0);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    check({output_pc, output_cc_id} == e, "out_thread", {output_pc, output_cc_id}, e);
                end
            end
        end
    end

    task automatic issue(input int pc, input int cc, input bit chk_addr);
        int n;
        model(pc, cc);
        @(posedge clk); #2;
        input_pc_valid = 1'b1;
        input_pc       = 9'(pc);
        input_cc_id    = 2'(cc);
        n = 0;
        @(negedge clk);
        while (!input_pc_ready && n < 200) begin @(negedge clk); n++; end
        check(input_pc_ready, "input_ready_timeout", 0, 1);
        @(posedge clk); #2;
        input_pc_valid = 1'b0;
        check(elaborating_chars[cc], "elaborating_set", elaborating_chars, cc);
        if (chk_addr) begin
            n = 0;
            @(negedge clk);
            while (!memory_valid && n < 200) begin @(negedge clk); n++; end
            check(memory_valid && memory_addr == 11'(pc), "memory_addr",
                  {memory_valid, memory_addr}, {1'b1, 11'(pc)});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((running || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        check(n < 3000, "idle_timeout", n, 3000);
        repeat (3) @(negedge clk);
        check(!running, "running_idle", running, 0);
        check(!output_pc_valid, "out_valid_idle", output_pc_valid, 0);
        check(elaborating_chars == 4'd0, "elab_idle", elaborating_chars, 0);
        check(exp_q.size() == 0, "outputs_missing", exp_q.size(), 0);
        check(acc_seen == exp_acc, "accept_count", acc_seen, exp_acc);
        acc_seen = 0;
        exp_acc  = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) prog[i] = {3'd4, 17'd0};
        for (int i = 0; i < 4; i++) chars[i] = 8'h41;

        repeat (3) @(negedge clk);
        check(!running && !output_pc_valid && !accepts && !memory_valid, "reset_outputs",
              {running, output_pc_valid, accepts, memory_valid}, 0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        check(!running, "idle_running", running, 0);
        check(!output_pc_valid, "idle_out_valid", output_pc_valid, 0);
        check(input_pc_ready, "idle_input_ready", input_pc_ready, 1);

        // NOT_MATCH with matching char: dropped
        prog[220] = {3'd7, 9'd0, 8'h41};
        issue(220, 1, 1'b1);
        wait_idle();

        // NOT_MATCH with different char: one output held under back-pressure
        prog[220] = {3'd7, 9'd0, 8'h42};
        hold_low = 8;
        issue(220, 3, 1'b1);
        wait_idle();

        // NOT_MATCH sweep
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 4; i++) chars[i] = 8'($urandom_range(65, 169));
            for (int p = 220; p < 260; p++) begin
                logic [7:0] c;
                c = chars[$urandom_range(0, 3)];
                if ($urandom_range(0, 1) == 1) c = c + 8'($urandom_range(1, 31));
                prog[p] = {3'd7, 9'd0, c};
            end
            for (int t = 0; t < 12; t++) issue($urandom_range(220, 259), $urandom_range(0, 3), 1'b1);
            wait_idle();
        end

        // SPLIT at the top of pc space, outputs stalled
        prog[511] = {3'd1, 17'd5};
        hold_low = 1000;
        issue(511, 0, 1'b1);
        begin
            int n;
            n = 0;
            while (!output_pc_valid && n < 200) begin @(negedge clk); n++; end
            check(output_pc_valid, "split_out_timeout", output_pc_valid, 1);
        end
        hold_low = 4;
        wait_idle();

        // ACCEPT with and without end of string
        prog[10] = {3'd0, 17'd0};
        end_of_string = 4'b0100;
        issue(10, 2, 1'b1);
        wait_idle();
        end_of_string = 4'b0000;
        issue(10, 2, 1'b1);
        wait_idle();

        // Random programs, characters and end-of-string flags
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 512; i++) prog[i] = 20'($urandom);
            for (int i = 0; i < 4; i++) chars[i] = 8'($urandom_range(0, 255));
            end_of_string = 4'($urandom);
            for (int i = 0; i < 8; i++) begin
                int p;
                p = $urandom_range(0, 511);
                prog[p] = {3'($urandom), 9'd0, chars[$urandom_range(0, 3)]};
            end
            for (int t = 0; t < 30; t++) issue($urandom_range(0, 511), $urandom_range(0, 3), 1'b1);
            wait_idle();
        end

        // Reset in the middle of activity
        prog[30] = {3'd3, 17'd100};
        prog[31] = {3'd1, 17'd7};
        hold_low = 1000;
        issue(30, 1, 1'b0);
        issue(31, 2, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        exp_q.delete();
        exp_acc  = 0;
        acc_seen = 0;
        @(negedge clk);
        check(!running && !output_pc_valid && elaborating_chars == 4'd0, "reset_flush",
              {running, output_pc_valid, elaborating_chars}, 0);
        @(posedge clk); #2 rst = 1'b0;
        hold_low = 0;
        repeat (5) @(negedge clk);
        check(!running && !output_pc_valid, "after_reset_idle", {running, output_pc_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
